// File: rtl/axis_to_ram.sv
// Captures one AXI-Stream packet into a DEPTH-word RAM, then closes the sink and flags done until re-armed.
// Read port is synchronous with 1-cycle latency; beats beyond DEPTH are dropped and flagged as overflow.
module axis_to_ram #(
  parameter int AXIS_BYTES = 1,
  parameter int DEPTH      = 2,
  localparam int W  = AXIS_BYTES * 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          sresetn,
  output logic          axis_tready,
  input  logic          axis_tvalid,
  input  logic          axis_tlast,
  input  logic [W-1:0]  axis_tdata,
  input  logic          rearm,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          done,
  output logic          overflow,
  output logic [LW-1:0] length
);

  typedef enum logic [1:0] {
    CAPTURE,
    DISCARD,
    DONE
  } state_t;

  localparam logic [LW-1:0] LAST_PTR  = LW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t        state, state_nxt;
  logic [LW-1:0] wr_ptr, wr_ptr_nxt;
  logic          overflow_nxt;
  logic          beat;
  logic          mem_we;
  logic [W-1:0]  mem [DEPTH];

  // Ready depends only on registered state, never on tvalid.
  assign axis_tready = sresetn && (state != DONE);
  assign beat        = axis_tvalid && axis_tready;
  assign done        = (state == DONE);
  assign length      = wr_ptr;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state    <= CAPTURE;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    overflow_nxt = overflow;
    mem_we       = 1'b0;
    case (state)
      CAPTURE: begin
        if (beat) begin
          mem_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (axis_tlast) begin
            state_nxt = DONE;
          end else if (wr_ptr == LAST_PTR) begin
            state_nxt = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (beat) begin
          overflow_nxt = 1'b1;
          if (axis_tlast) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (rearm) begin
          state_nxt    = CAPTURE;
          wr_ptr_nxt   = '0;
          overflow_nxt = 1'b0;
        end
      end
      default: state_nxt = CAPTURE;
    endcase
  end

  // Writes only happen in CAPTURE, where wr_ptr is always below DEPTH.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[AW-1:0]] <= axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < DEPTH_EXT) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_axis_to_ram.sv
// Scoreboarded bench for axis_to_ram: directed packets plus random packets with gaps,
// checked against a packet-level model of what the RAM and status outputs must show.
module tb_axis_to_ram;

  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [LW-1:0] len;
    logic          ovf;
  } pkt_t;

  logic          clk = 1'b0;
  logic          sresetn = 1'b0;
  logic          axis_tready;
  logic          axis_tvalid = 1'b0;
  logic          axis_tlast = 1'b0;
  logic [W-1:0]  axis_tdata = '0;
  logic          rearm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          done;
  logic          overflow;
  logic [LW-1:0] length;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] rd_q [$];
  pkt_t         done_q [$];
  logic [W-1:0] pkt [$];
  logic         rd_req = 1'b0;
  logic         rd_pend = 1'b0;
  logic         done_prev = 1'b0;
  pkt_t         mon_p;
  logic [W-1:0] mon_e;

  always #5 clk = ~clk;

  axis_to_ram #(.AXIS_BYTES(1), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .sresetn     (sresetn),
    .axis_tready (axis_tready),
    .axis_tvalid (axis_tvalid),
    .axis_tlast  (axis_tlast),
    .axis_tdata  (axis_tdata),
    .rearm       (rearm),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .done        (done),
    .overflow    (overflow),
    .length      (length)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read requests issued on a negedge are answered by the following negedge.
  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      chk("rd_q_nonempty", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) begin
        mon_e = rd_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_e));
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      chk("done_q_nonempty", 32'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        mon_p = done_q.pop_front();
        chk("done_length", 32'(length), 32'(mon_p.len));
        chk("done_overflow", 32'(overflow), 32'(mon_p.ovf));
        chk("done_tready", 32'(axis_tready), 0);
      end
    end
    done_prev = done;
  end

  task automatic send_beat(input logic [W-1:0] d, input logic last, input bit gaps);
    int w;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        axis_tvalid = 1'b0;
        axis_tdata  = W'($urandom);
        axis_tlast  = 1'($urandom);
        rearm       = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      rearm = 1'b0;
    end
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tlast  = last;
    w = 0;
    while (!axis_tready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("beat_tready", 32'(axis_tready), 1);
    @(negedge clk);
  endtask

  task automatic send_packet(input logic [W-1:0] d [$], input bit gaps);
    int   n;
    pkt_t p;
    n     = d.size();
    p.len = (n > DEPTH) ? LW'(DEPTH) : LW'(n);
    p.ovf = (n > DEPTH);
    done_q.push_back(p);
    for (int i = 0; i < n; i++) begin
      send_beat(d[i], (i == n - 1), gaps);
      if (i < DEPTH) model_mem[i] = d[i];
      chk("live_length", 32'(length), (i + 1 > DEPTH) ? DEPTH : i + 1);
      chk("live_overflow", 32'(overflow), 32'(i + 1 > DEPTH));
      chk("live_done", 32'(done), 32'(i == n - 1));
    end
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
  endtask

  task automatic read_back(input int n);
    for (int a = 0; a < n; a++) begin
      rd_addr = a[AW-1:0];
      rd_req  = 1'b1;
      rd_q.push_back(model_mem[a]);
      @(negedge clk);
    end
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_rearm(input bit hold_valid);
    chk("pre_rearm_done", 32'(done), 1);
    axis_tvalid = hold_valid;
    axis_tdata  = 8'h99;
    axis_tlast  = 1'b1;
    rearm       = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    chk("rearm_length", 32'(length), 0);
    chk("rearm_done", 32'(done), 0);
    chk("rearm_overflow", 32'(overflow), 0);
    chk("rearm_tready", 32'(axis_tready), 1);
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    sresetn = 1'b0;
    rearm   = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_tready", 32'(axis_tready), 0);
    end
    chk("rst_length", 32'(length), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    axis_tvalid = 1'b0;
    sresetn     = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", 32'(axis_tready), 1);
    chk("post_rst_length", 32'(length), 0);
    chk("post_rst_done", 32'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    @(negedge clk);
    apply_reset(3);

    pkt = '{8'hAA, 8'hBB, 8'hCC};
    send_packet(pkt, 1'b0);
    read_back(3);
    do_rearm(1'b0);

    pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_packet(pkt, 1'b0);
    read_back(4);
    do_rearm(1'b0);

    pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    send_packet(pkt, 1'b0);
    read_back(4);

    // Source keeps pushing while the sink is closed.
    axis_tvalid = 1'b1;
    axis_tdata  = 8'h5A;
    axis_tlast  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("closed_tready", 32'(axis_tready), 0);
      chk("closed_length", 32'(length), DEPTH);
      chk("closed_overflow", 32'(overflow), 1);
    end
    do_rearm(1'b1);

    pkt = '{8'h7E};
    send_packet(pkt, 1'b0);
    read_back(2);
    do_rearm(1'b0);

    pkt = '{8'hC1};
    send_packet(pkt, 1'b1);
    read_back(1);
    do_rearm(1'b0);

    pkt = '{8'hAA, 8'hBB, 8'hCC};
    send_packet(pkt, 1'b1);
    read_back(3);
    do_rearm(1'b0);

    // Abandon a packet part-way with reset; the RAM keeps what was written.
    send_beat(8'h33, 1'b0, 1'b0);
    send_beat(8'h44, 1'b0, 1'b0);
    model_mem[0] = 8'h33;
    model_mem[1] = 8'h44;
    chk("midpkt_length", 32'(length), 2);
    apply_reset(2);
    pkt = '{8'h55, 8'h66};
    send_packet(pkt, 1'b0);
    read_back(DEPTH);
    do_rearm(1'b0);

    repeat (20) begin
      n = $urandom_range(1, DEPTH + 3);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(W'($urandom));
      send_packet(pkt, 1'b1);
      read_back(DEPTH);
      do_rearm(1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_to_ram.md
# axis_to_ram

Stream-capture sink: accepts one AXI-Stream packet, stores its beats in an internal RAM of DEPTH words, then stops accepting and flags completion. Stored words are read back through a synchronous random-access read port. It is the receiving counterpart to the ROM-to-stream source: it captures stimulus or response packets for software or bench readback. It re-arms on request to capture the next packet.

## Interface

Parameters:

- AXIS_BYTES, 1, stream width in bytes; word width W = AXIS_BYTES*8.
- DEPTH, 2, RAM words (≥2); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).

Ports:

- clk  in  1  clock; all logic on posedge.
- sresetn  in  1  synchronous, active-low reset.
- axis_tready  out  1  sink ready.
- axis_tvalid  in  1  source valid.
- axis_tlast  in  1  last beat of packet.
- axis_tdata  in  W  beat data.
- rearm  in  1  single-cycle request to capture the next packet.
- rd_addr  in  AW  read address.
- rd_data  out  W  registered read data.
- done  out  1  packet captured; sink closed.
- overflow  out  1  captured packet exceeded DEPTH beats.
- length  out  LW  number of beats stored in RAM.

## Operation

- Beat = cycle with axis_tvalid && axis_tready.
- Internal write pointer wr_ptr has LW bits.
- FSM has three states: CAPTURE (reset state), DISCARD, DONE.
- axis_tready = sresetn && (state != DONE). It is combinational from registered state only, with no combinational path from axis_tvalid.
- CAPTURE, on each beat:
  - mem[wr_ptr] <= axis_tdata; wr_ptr++; length++.
  - Beat with tlast → DONE.
  - Beat without tlast at wr_ptr == DEPTH-1 (RAM now full) → DISCARD.
- DISCARD, on each beat:
  - Data dropped; wr_ptr and length hold at DEPTH.
  - overflow <= 1 on the first discarded beat.
  - Beat with tlast → DONE.
- A tlast on the DEPTH-th beat → DONE with overflow 0 and length DEPTH.
- DONE:
  - done = 1; tready = 0.
  - length, overflow and RAM contents hold.
  - rearm → CAPTURE; wr_ptr, length, overflow and done clear on the same edge.
  - RAM is not cleared; the next packet overwrites it from address 0.
- rearm in CAPTURE or DISCARD is ignored.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, independent of FSM state.
  - rd_addr ≥ DEPTH (non-power-of-2 DEPTH) returns 0.
  - A read and a write to the same address in the same cycle returns the old (read-before-write) data.

## Timing

- Reset values: state CAPTURE, wr_ptr 0, length 0, done 0, overflow 0, rd_data 0. axis_tready is 0 while sresetn is low. RAM is not reset.
- Ready latency: axis_tready goes high the first cycle after sresetn returns high.
- done latency: done rises the cycle after the tlast beat; axis_tready falls in that same cycle.
- Back-to-back beats are accepted at one per cycle. Source gaps (tvalid low) stall capture with no effect on state.
- length is live: it is updated the cycle after each stored beat.
- overflow rises the cycle after the first discarded beat.
- rearm and tvalid asserted together in DONE: no beat is accepted that cycle. The first beat is accepted the next cycle.
- Read latency is 1 cycle (rd_addr at edge N → rd_data valid after edge N).
- Reset mid-packet: returns to CAPTURE with length 0. The partial packet is abandoned and its RAM words remain but are not reported.

## Test plan

- DEPTH=4, W=8; beats AA,BB,CC with tlast on CC, continuous:
  - done=1 and tready=0 one cycle after the CC beat; length=3, overflow=0.
  - rd_addr 0,1,2 returns AA,BB,CC with 1-cycle latency.
- Exactly 4 beats 01..04, tlast on 04 → done, length=4, overflow=0; readback 01..04.
- 6 beats 10..15, tlast on 15:
  - All 6 accepted; RAM holds 10..13; length=4.
  - overflow=1 from the cycle after beat 14; done after beat 15.
- In DONE, hold tvalid=1 with 5 cycles of no handshake, then pulse rearm:
  - length, done and overflow clear next cycle.
  - A 1-beat packet 7E with tlast → length=1, rd addr0=7E, addr1 still holds the old value.
- Single-beat packet with tvalid gaps and random tvalid toggling over a 3-beat packet → identical result to the continuous case.
- Reset asserted after 2 beats of a packet:
  - tready=0 during reset; length=0, done=0 afterwards.
  - A new 2-beat packet 55,66 → length=2, readback 55,66.
